reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-read-port register file with registered reads, same-cycle write-to-read bypass and a per-register busy scoreboard. It is the next-generation processor register file: one write port and NUM_RD independent read ports operate in the same cycle, with no READ/WRITE exclusivity. Register 0 is optionally hardwired to zero. It sits between decode (reads and reservations) and writeback (writes).

## Interface
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: address width; depth = 2**ADDR_WIDTH.
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: 1 = register 0 reads 0 and ignores writes and reservations.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- RD_EN  in  NUM_RD  per-port read request.
- RD_ADDR  in  NUM_RD*ADDR_WIDTH  packed read addresses; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- RD_DATA  out  NUM_RD*DATA_WIDTH  packed registered read data.
- RD_VALID  out  NUM_RD  high for one cycle when the port's RD_DATA is updated.
- RD_BUSY  out  NUM_RD  busy bit of the addressed register, captured with RD_DATA.
- WR_EN  in  1  write request.
- WR_ADDR  in  ADDR_WIDTH  write address.
- WR_DATA  in  DATA_WIDTH  write data.
- RSV_EN  in  1  reservation request: mark RSV_ADDR busy.
- RSV_ADDR  in  ADDR_WIDTH  register to reserve.
- RSV_READY  out  1  combinational; reservation is accepted on a rising edge when RSV_EN && RSV_READY.

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH array plus a 2**ADDR_WIDTH busy vector.
- Write: WR_EN=1 writes WR_DATA to WR_ADDR and clears busy[WR_ADDR].
- Reservation: an accepted RSV_EN sets busy[RSV_ADDR].
- RSV_READY = !busy[RSV_ADDR] || (WR_EN && WR_ADDR==RSV_ADDR). A write that frees the register in the same cycle permits re-reservation.
- Same-address write and accepted reservation in one cycle: the write stores data and busy ends at 1, so the reservation wins.
- Read, per port p: RD_EN[p]=1 loads RD_DATA[p] from RD_ADDR[p], loads RD_BUSY[p], and pulses RD_VALID[p].
  - With RD_EN[p]=0, RD_DATA[p] and RD_BUSY[p] hold their value and RD_VALID[p]=0.
- Multiple ports may read the same address in the same cycle; all get identical results.
- With ZERO_REG=1 and address 0:
  - reads return 0 with busy 0;
  - writes are discarded;
  - RSV_READY=1 and the reservation has no effect.
- Reset: array cleared to 0, busy vector cleared, RD_DATA=0, RD_BUSY=0, RD_VALID=0. Reset asserted mid-operation discards any in-flight read, write or reservation in that cycle.

## Timing
- Read latency is 1 cycle: address and enable sampled at edge N, data, busy and valid visible after edge N.
- Write takes effect at the edge. A read issued in the next cycle sees the new data with no configuration dependency.
- Same-cycle read and write to the same address: see Configuration.
- RSV_READY is combinational from RSV_ADDR, WR_EN, WR_ADDR and the busy vector. No combinational path exists from any input to RD_*.
- Reset takes effect immediately. The first operation is accepted on the first rising edge after RST falls.

## Configuration
- Macro: REG_FILE_MP_BYPASS_EN.
- Defined: a same-cycle write to RD_ADDR[p] forwards WR_DATA into RD_DATA[p] and reports RD_BUSY[p]=0, since the write clears busy. A concurrent accepted reservation makes it 1.
- Undefined: the read returns the pre-write array content and the pre-write busy bit. The written value is visible from the next read.
- The ZERO_REG rule overrides the bypass: a read of address 0 always returns 0.

## Structure
- Shared package/definitions file: default DATA_WIDTH and ADDR_WIDTH (32/5, matching existing data and register-address limits), NUM_RD default, and the zero-register address constant.
- Sub-module reg_file_rd_port: one read port containing address decode, bypass mux, output registers and valid. It is instantiated NUM_RD times by a generate loop. Array, busy vector and write/reservation logic stay in the top.

## Test plan
- Reset then read all 32 addresses on both ports -> RD_DATA=0, RD_BUSY=0, RD_VALID pulses one cycle after each RD_EN.
- Write 0xDEADBEEF to r5, then in the next cycle read r5 on port 0 and r5 on port 1 -> both RD_DATA=0xDEADBEEF one cycle later.
- Same-cycle write 0x12345678 to r7 and read r7 (r7 previously 0xA5A5A5A5) -> 0x12345678 with REG_FILE_MP_BYPASS_EN, 0xA5A5A5A5 without.
- Reserve r3, then read r3 -> RD_BUSY=1. Next, RSV_EN on r3 -> RSV_READY=0 and busy unchanged. Then write r3 and reserve r3 in the same cycle -> RSV_READY=1 and busy remains 1.
- ZERO_REG=1: write 0xFFFFFFFF to r0 with RSV_EN on r0, then read r0 -> RD_DATA=0, RD_BUSY=0.
- Assert RST mid-stream while a write to r9 and a read are pending -> r9 reads 0 afterwards, RD_VALID stays 0 during reset, busy vector all 0.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared defaults for the multi-read-port register file.
package reg_file_mp_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_NUM_RD     = 2;
   localparam int ZERO_ADDR      = 0;
endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: address select, optional write bypass, output registers.
// Optional feature: REG_FILE_MP_BYPASS_EN forwards a same-cycle write into the read.
module reg_file_rd_port
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int ZERO_REG   = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH],
   input  logic [2**ADDR_WIDTH-1:0] busy_vec,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rsv_en,
   input  logic [ADDR_WIDTH-1:0] rsv_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_busy,
   output logic                  rd_valid
);
   localparam logic [ADDR_WIDTH-1:0] ZA = ADDR_WIDTH'(ZERO_ADDR);

   logic [DATA_WIDTH-1:0] nxt_data;
   logic                  nxt_busy;

   always_comb begin
      nxt_data = mem[rd_addr];
      nxt_busy = busy_vec[rd_addr];
`ifdef REG_FILE_MP_BYPASS_EN
      // wr_en/rsv_en arrive already qualified, so a hit here is a real update
      if (wr_en && (wr_addr == rd_addr)) begin
         nxt_data = wr_data;
         nxt_busy = rsv_en && (rsv_addr == rd_addr);
      end
`endif
      if ((ZERO_REG != 0) && (rd_addr == ZA)) begin
         nxt_data = '0;
         nxt_busy = 1'b0;
      end
   end

`ifndef REG_FILE_MP_BYPASS_EN
   logic unused_bypass;
   assign unused_bypass = ^{wr_en, wr_addr, wr_data, rsv_en, rsv_addr};
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_data  <= '0;
         rd_busy  <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= nxt_data;
            rd_busy <= nxt_busy;
         end
      end
   end
endmodule

// File: rtl/reg_file_mp.sv
// Register file: one write port, NUM_RD registered read ports, busy scoreboard.
// Optional feature: REG_FILE_MP_BYPASS_EN (same-cycle write-to-read forwarding).
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_RD     = DEF_NUM_RD,
   parameter int ZERO_REG   = 1
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [NUM_RD-1:0]            RD_EN,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] RD_ADDR,
   output logic [NUM_RD*DATA_WIDTH-1:0] RD_DATA,
   output logic [NUM_RD-1:0]            RD_VALID,
   output logic [NUM_RD-1:0]            RD_BUSY,
   input  logic                         WR_EN,
   input  logic [ADDR_WIDTH-1:0]        WR_ADDR,
   input  logic [DATA_WIDTH-1:0]        WR_DATA,
   input  logic                         RSV_EN,
   input  logic [ADDR_WIDTH-1:0]        RSV_ADDR,
   output logic                         RSV_READY
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZA = ADDR_WIDTH'(ZERO_ADDR);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      busy;
   logic                  wr_zero, rsv_zero, wr_do, rsv_do;

   assign wr_zero   = (ZERO_REG != 0) && (WR_ADDR == ZA);
   assign rsv_zero  = (ZERO_REG != 0) && (RSV_ADDR == ZA);
   assign RSV_READY = rsv_zero || !busy[RSV_ADDR] || (WR_EN && (WR_ADDR == RSV_ADDR));
   assign wr_do     = WR_EN && !wr_zero;
   assign rsv_do    = RSV_EN && RSV_READY && !rsv_zero;

   // Reservation is applied after the write so it wins on a shared address
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         busy <= '0;
      end else begin
         if (wr_do) begin
            mem[WR_ADDR]  <= WR_DATA;
            busy[WR_ADDR] <= 1'b0;
         end
         if (rsv_do) busy[RSV_ADDR] <= 1'b1;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      reg_file_rd_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .ZERO_REG   (ZERO_REG)
      ) u_port (
         .CLK      (CLK),
         .RST      (RST),
         .rd_en    (RD_EN[p]),
         .rd_addr  (RD_ADDR[p*ADDR_WIDTH +: ADDR_WIDTH]),
         .mem      (mem),
         .busy_vec (busy),
         .wr_en    (wr_do),
         .wr_addr  (WR_ADDR),
         .wr_data  (WR_DATA),
         .rsv_en   (rsv_do),
         .rsv_addr (RSV_ADDR),
         .rd_data  (RD_DATA[p*DATA_WIDTH +: DATA_WIDTH]),
         .rd_busy  (RD_BUSY[p]),
         .rd_valid (RD_VALID[p])
      );
   end
endmodule
